zz_reorder_buf: RTL and testbench

- Ping-pong 8x8 block buffer that consumes the coefficient stream leaving the 2-D DCT (raster order, one word per cycle) and emits it in JPEG zigzag scan order.
- Sits between the DCT/quantizer stage and the run-length/entropy coder.
- Uses a valid/ready handshake on both sides. Sustains 1 word/cycle throughput when the downstream never stalls.

---
 rtl/jpeg_pkg.sv | 25 ++
 rtl/zz_addr_lut.sv | 17 +
 rtl/zz_reorder_buf.sv | 119 +++++++++++
 tb/tb_zz_reorder_buf.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants and types for the JPEG coefficient-path blocks.
//   BLK_N       : block edge length (8)
//   BLK_WORDS   : coefficients per block (64)
//   coef_idx_t  : 6-bit coefficient index within a block
//   ZZ          : zigzag position -> raster index (row*8+col)
package jpeg_pkg;

  localparam int BLK_N     = 8;
  localparam int BLK_WORDS = BLK_N * BLK_N;

  typedef logic [5:0] coef_idx_t;

  // Entry p holds the raster index of the coefficient at zigzag position p.
  localparam coef_idx_t ZZ [0:BLK_WORDS-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zz_addr_lut.sv
// zz_addr_lut: combinational zigzag-position to raster-address map.
// Shared with the decoder-side de-zigzag block.
//   zz_pos      in  6  zigzag scan position 0..63
//   raster_addr out 6  raster index (row*8+col) of that position
module zz_addr_lut
  import jpeg_pkg::*;
(
  input  coef_idx_t zz_pos,
  output coef_idx_t raster_addr
);

  // Pure table lookup.
  always_comb begin
    raster_addr = ZZ[zz_pos];
  end

endmodule

// File: rtl/zz_reorder_buf.sv
// zz_reorder_buf: ping-pong 8x8 block buffer converting the DCT coefficient
// stream (one word per cycle) into JPEG zigzag scan order.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : coefficient word (raster order, or column-major when
//                ZZ_COL_MAJOR_IN_EN is defined)
//   in_valid / in_ready   : input handshake (in_ready = bank being written empty)
//   out_data / out_valid / out_ready : registered output handshake
//   out_idx    : zigzag position of out_data
//   out_last   : marks zigzag position 63
// Build option: define ZZ_COL_MAJOR_IN_EN for column-major input
// (index = col*8+row); output order is identical either way.
module zz_reorder_buf
  import jpeg_pkg::*;
#(
  parameter int BW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [5:0]    out_idx,
  output logic          out_last
);

  logic [BW-1:0] mem_r [0:1][0:BLK_WORDS-1];
  logic [1:0]    full_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  coef_idx_t     wr_cnt_r;
  coef_idx_t     rd_cnt_r;

  logic          wr_fire_s;
  logic          load_s;
  logic          wr_wrap_s;
  logic          rd_wrap_s;
  coef_idx_t     wr_addr_s;
  coef_idx_t     rd_addr_s;
  logic [1:0]    full_set_s;
  logic [1:0]    full_clr_s;
  logic [1:0]    full_nxt_s;

  zz_addr_lut u_lut (
    .zz_pos      (rd_cnt_r),
    .raster_addr (rd_addr_s)
  );

  // Handshake qualifiers, write address and full-flag next state.
  always_comb begin
    in_ready  = ~full_r[wr_bank_r];
    wr_fire_s = in_valid & ~full_r[wr_bank_r];
    load_s    = full_r[rd_bank_r] & (~out_valid | out_ready);
    wr_wrap_s = (wr_cnt_r == 6'd63);
    rd_wrap_s = (rd_cnt_r == 6'd63);
`ifdef ZZ_COL_MAJOR_IN_EN
    // Column-major input: swap row and column fields to get raster address.
    wr_addr_s = {wr_cnt_r[2:0], wr_cnt_r[5:3]};
`else
    wr_addr_s = wr_cnt_r;
`endif
    // Set and clear always target different banks, so both may apply at once.
    full_set_s = (wr_fire_s & wr_wrap_s) ? (2'b01 << wr_bank_r) : 2'b00;
    full_clr_s = (load_s & rd_wrap_s) ? (2'b01 << rd_bank_r) : 2'b00;
    full_nxt_s = (full_r | full_set_s) & ~full_clr_s;
  end

  // Block storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][wr_addr_s] <= in_data;
    end
  end

  // Write/read pointers and bank full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= 6'd0;
      rd_cnt_r  <= 6'd0;
    end else begin
      full_r <= full_nxt_s;
      if (wr_fire_s) begin
        wr_cnt_r <= wr_cnt_r + 6'd1;
        if (wr_wrap_s) begin
          wr_bank_r <= ~wr_bank_r;
        end
      end
      if (load_s) begin
        rd_cnt_r <= rd_cnt_r + 6'd1;
        if (rd_wrap_s) begin
          rd_bank_r <= ~rd_bank_r;
        end
      end
    end
  end

  // Output register: load next zigzag word, drop valid once consumed, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= {BW{1'b0}};
      out_valid <= 1'b0;
      out_idx   <= 6'd0;
      out_last  <= 1'b0;
    end else if (load_s) begin
      out_data  <= mem_r[rd_bank_r][rd_addr_s];
      out_valid <= 1'b1;
      out_idx   <= rd_cnt_r;
      out_last  <= rd_wrap_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zz_reorder_buf.sv
// tb_zz_reorder_buf: self-checking bench for zz_reorder_buf.
// A block-level reference model collects 64 accepted words into an 8x8
// array and queues them in zigzag order, where the zigzag order is derived
// by walking the anti-diagonals of the block.
module tb_zz_reorder_buf;

  localparam int BW = 12;
`ifdef ZZ_COL_MAJOR_IN_EN
  localparam bit COL_MAJOR = 1'b1;
`else
  localparam bit COL_MAJOR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_idx;
  logic          out_last;

  zz_reorder_buf #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  typedef struct {
    logic [BW-1:0] din;
    logic [BW-1:0] exp_dout;
    logic [5:0]    exp_idx;
    logic          exp_last;
  } vec_t;

  exp_t exp_q[$];
  vec_t vec [64];
  int   zz_seq [64];
  int   blk_buf [64];
  int   blk_cnt;

  int   log_data[$];
  int   log_cyc[$];
  int   cyc;

  bit            held;
  logic [BW-1:0] h_data;
  logic [5:0]    h_idx;
  logic          h_last;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int raster_of(input int i);
    if (COL_MAJOR) return (i % 8) * 8 + i / 8;
    else return i;
  endfunction

  task automatic build_zigzag();
    int p;
    int lo;
    int hi;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_seq[p] = r * 8 + (s - r);
          p++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_seq[p] = r * 8 + (s - r);
          p++;
        end
      end
    end
  endtask

  task automatic model_push(input int d);
    exp_t e;
    blk_buf[raster_of(blk_cnt)] = d;
    blk_cnt++;
    if (blk_cnt == 64) begin
      for (int p = 0; p < 64; p++) begin
        e.data = blk_buf[zz_seq[p]];
        e.idx  = p;
        e.last = (p == 63);
        exp_q.push_back(e);
      end
      blk_cnt = 0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance.
  task automatic cycle(input logic iv, input logic [BW-1:0] id, input logic ordy, output bit acc);
    exp_t e;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    if (held) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, h_data);
      check("hold_idx", out_idx, h_idx);
      check("hold_last", out_last, h_last);
    end
    acc = iv && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_word: got %0d required none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_idx", out_idx, e.idx);
        check("out_last", out_last, e.last);
      end
      log_data.push_back(int'(out_data));
      log_cyc.push_back(cyc);
    end
    held   = out_valid && !ordy;
    h_data = out_data;
    h_idx  = out_idx;
    h_last = out_last;
    if (acc) model_push(int'(id));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    blk_cnt = 0;
    held    = 1'b0;
  endtask

  task automatic send_word(input logic [BW-1:0] d, input logic ordy, inout int stalls);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 1000) begin
      cycle(1'b1, d, ordy, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
    stalls += tries - 1;
  endtask

  task automatic send_block(input int base, input logic ordy, inout int stalls);
    for (int i = 0; i < 64; i++) send_word(BW'(base + raster_of(i)), ordy, stalls);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 2000) begin
      cycle(1'b0, '0, 1'b1, acc);
      n++;
    end
    check("drain_in_budget", (n < 2000), 1);
    check("no_lost_words", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int stalls;
    int bubbles;
    int k;
    bit done;

    build_zigzag();
    blk_cnt = 0;
    held    = 1'b0;
    cyc     = 0;
    stalls  = 0;
    rst     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);

    // Single block, data = raster index, table-driven.
    for (int i = 0; i < 64; i++) begin
      vec[i].din      = BW'(raster_of(i));
      vec[i].exp_dout = BW'(zz_seq[i]);
      vec[i].exp_idx  = 6'(i);
      vec[i].exp_last = (i == 63);
    end
    log_data.delete();
    log_cyc.delete();
    for (int i = 0; i < 64; i++) send_word(vec[i].din, 1'b1, stalls);
    check("lat_edge_e_valid", out_valid, 0);
    cycle(1'b0, '0, 1'b1, acc);
    check("lat_edge_e1_valid", out_valid, 1);
    drain();
    check("blk1_count", log_data.size(), 64);
    for (int i = 0; i < 64 && i < log_data.size(); i++) begin
      check("tbl_data", log_data[i], vec[i].exp_dout);
    end

    // Three back-to-back blocks, no stalls, no bubbles.
    log_data.delete();
    log_cyc.delete();
    stalls = 0;
    for (int b = 0; b < 3; b++) send_block(64 * b, 1'b1, stalls);
    drain();
    check("b2b_in_ready_drops", stalls, 0);
    check("b2b_count", log_data.size(), 192);
    bubbles = 0;
    for (int i = 1; i < log_cyc.size(); i++) begin
      if (log_cyc[i] != log_cyc[i-1] + 1) bubbles++;
    end
    check("b2b_bubbles", bubbles, 0);
    if (log_data.size() >= 67) begin
      check("b2b_blk1_w0", log_data[64], 64);
      check("b2b_blk1_w1", log_data[65], 65);
      check("b2b_blk1_w2", log_data[66], 72);
    end

    // Two blocks with out_ready low: both banks fill.
    stalls = 0;
    send_block(0, 1'b0, stalls);
    send_block(64, 1'b0, stalls);
    #1;
    check("both_full_in_ready", in_ready, 0);
    check("both_full_stalls", stalls, 0);
    k    = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      #1;
      check("release_in_ready", in_ready, (out_valid && out_last) ? 1 : 0);
      if (out_valid && out_last) done = 1'b1;
      cycle(1'b0, '0, 1'b1, acc);
      k++;
    end
    check("release_seen", done, 1);
    drain();

    // Reset mid-stream with output pending.
    stalls = 0;
    send_block(0, 1'b0, stalls);
    for (int i = 0; i < 30; i++) send_word(BW'(500 + i), 1'b0, stalls);
    check("pre_rst_pending", out_valid, 1);
    do_reset();
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    log_data.delete();
    log_cyc.delete();
    send_block(200, 1'b1, stalls);
    drain();
    check("post_rst_count", log_data.size(), 64);
    if (log_data.size() >= 3) begin
      check("post_rst_w0", log_data[0], 200);
      check("post_rst_w1", log_data[1], 201);
      check("post_rst_w2", log_data[2], 208);
    end

    // Random valid/ready traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), BW'($urandom), 1'($urandom_range(0, 1)), acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
